mem_data_provider: RTL
======================

# mem_data_provider

Memory-side responder for the CPU control path. It owns the address register and services fetch, load and store requests issued by the instruction decoder and logic control (`update_address`, `address_reg_sel`, `mem_write_en`, `data_out_en`, `data_prov_b_bus_en`). It runs a single-outstanding request/acknowledge transaction to external word memory and returns the fetched instruction word to the decoder. Loaded data goes onto the shared B bus.

## Interface
- `ADDR_W`, 32: external memory address width; `mem_addr` carries the low `ADDR_W` bits of the address register.
- `RESET_ADDR`, 32'h0000_0000: address register value after reset.
- `NOP_WORD`, 32'hE1A0_0000: MOV R0,R0; instruction value after reset and on timeout.
- `TIMEOUT`, 16: wait-cycle limit for an acknowledge. Used only with `MEM_DATA_PROVIDER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `update_address` in 1: start transaction.
- `address_reg_sel` in 2: 00 ALU, 01 PC, 10 INC, 11 hold.
- `alu_bus` in 32: ALU result, used as address source.
- `pc_bus` in 32: PC value, used as address source.
- `mem_write_en` in 1: sampled with `update_address`. 1 = store, 0 = read.
- `write_data` in 32: store data, sampled with `update_address`.
- `data_out_en` in 1: enables `b_bus` drive.
- `data_prov_b_bus_en` in 1: enables `b_bus` drive. `b_bus` is driven only when both enables are 1.
- `instruction` out 32: last fetched word (`mem_data_prov_instruction`).
- `instr_valid` out 1: one-cycle pulse on read completion.
- `b_bus` out 32: tri-state; load data register, otherwise high-Z.
- `busy` out 1: transaction in flight.
- `overrun` out 1: sticky; set when `update_address` arrives while busy.
- `timeout_err` out 1: sticky; set on timeout. Stays 0 when the macro is off.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_wdata` out 32: request side to memory.
- `mem_rdata` in 32, `mem_ack` in 1: response side from memory.

## Operation
- State machine states: IDLE, READ, WRITE.
- IDLE with `update_address`=1, registered on the next edge:
  - Address register loads according to `address_reg_sel`.
  - Bits [1:0] are forced to 0, so all accesses are word aligned.
  - INC adds 4 modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
  - Hold (11) keeps the current address but still issues the access.
  - Next state is WRITE if `mem_write_en`=1, otherwise READ.
  - `write_data` is captured into `mem_wdata`.
- READ or WRITE:
  - `mem_req`=1 and `busy`=1; `mem_we`=1 only in WRITE.
  - `mem_addr`, `mem_we` and `mem_wdata` are stable until `mem_ack` is sampled high.
  - When `mem_ack` is sampled high, the FSM returns to IDLE and `mem_req` drops on that same edge.
- READ completion:
  - `mem_rdata` is captured into both `instruction` and the load data register.
  - `instr_valid`=1 for exactly one cycle.
- WRITE completion: `instruction` and the load data register are unchanged, and there is no `instr_valid` pulse.
- `update_address` while busy is dropped: the address register and the in-flight transaction are unaffected, and `overrun` is set to 1.
- `mem_ack` in IDLE is ignored.
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=`RESET_ADDR`, `mem_wdata`=0, `instruction`=`NOP_WORD`, load data register=0, `instr_valid`=0, `busy`=0, `overrun`=0, `timeout_err`=0, state IDLE.
- `b_bus` follows the enables combinationally; it is high-Z in reset unless both enables are 1.
- Reset mid-transaction abandons the request: `mem_req` is 0 after the reset edge, and a late `mem_ack` is ignored.

## Timing
- Cycle T: `update_address`=1 sampled.
- Edge T+1: address is registered and `mem_req`=1.
- Zero-wait memory (`mem_ack` high during T+1): data is captured at edge T+2, and `instr_valid` is high from T+2 to T+3.
- Read latency is 2 + N cycles from `update_address` to `instr_valid`, where N is the number of memory wait cycles.
- `busy` is high for 1 + N cycles.
- A new `update_address` is accepted in the cycle `instr_valid` is high, giving back-to-back fetch at one word per 2 cycles.

## Configuration
- `MEM_DATA_PROVIDER_TIMEOUT_EN` defined:
  - A wait counter clears on entry to READ/WRITE and counts cycles with `mem_ack`=0.
  - When the counter reaches `TIMEOUT`, the FSM returns to IDLE, `mem_req` drops and `timeout_err` is set.
  - A timed-out READ loads `NOP_WORD` into `instruction` and pulses `instr_valid`.
  - A timed-out WRITE is discarded.
  - If `mem_ack` and the limit coincide, the ack wins.
- `MEM_DATA_PROVIDER_TIMEOUT_EN` undefined: no counter; the FSM waits indefinitely and `timeout_err` is tied 0.

## Test plan
- Reset, then `update_address`=1 with sel=PC, `pc_bus`=0x100, ack with 0 waits, `mem_rdata`=0xE3A01005 -> `mem_addr`=0x100, `instruction`=0xE3A01005, `instr_valid` at T+2 only.
- Address arithmetic: sel=ALU with `alu_bus`=0x103 -> `mem_addr`=0x100; then INC from 0xFFFFFFFC -> 0x00000000.
- Store: `mem_write_en`=1, `alu_bus`=0x2000, `write_data`=0xDEADBEEF, ack after 3 waits -> `mem_we`=1, `mem_wdata`=0xDEADBEEF held 4 cycles, `busy` 4 cycles, no `instr_valid`, `instruction` unchanged.
- `update_address` with sel=ALU, `alu_bus`=0x400 during a pending read at 0x100 -> `overrun`=1, `mem_addr` stays 0x100, completes normally.
- Macro on, `TIMEOUT`=16, no ack -> `mem_req` drops after 16 wait cycles, `timeout_err`=1, `instruction`=0xE1A00000, one `instr_valid`; macro off -> `mem_req` still high after 100 cycles.
- `reset`=0 during a read wait, then ack one cycle later -> `mem_req`=0, `instruction`=0xE1A00000, no `instr_valid`; `b_bus` drives load data only when both enables are 1, high-Z otherwise.

Source files
------------

// File: rtl/mem_data_provider.sv
`timescale 1ns/1ps
// mem_data_provider: address register plus a single-outstanding request/ack port to word memory.
// Define MEM_DATA_PROVIDER_TIMEOUT_EN to abort a transaction after TIMEOUT cycles without mem_ack.
module mem_data_provider #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'hE1A0_0000,
    parameter int          TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              update_address,
    input  logic [1:0]        address_reg_sel,
    input  logic [31:0]       alu_bus,
    input  logic [31:0]       pc_bus,
    input  logic              mem_write_en,
    input  logic [31:0]       write_data,
    input  logic              data_out_en,
    input  logic              data_prov_b_bus_en,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [31:0]       b_bus,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] w_addr_src;
    logic [31:0] w_addr_nxt;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_instr;
    logic [31:0] r_load_data;
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_instr_valid;
    logic        r_overrun;
    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic        w_timeout_hit;
    logic        w_in_flight;
    logic        w_overrun;
    logic        w_b_bus_en;

    if (TIMEOUT < 1 || ADDR_W < 3 || ADDR_W > 32) begin : g_param_check
        $error("mem_data_provider: TIMEOUT must be >= 1 and ADDR_W within 3..32");
    end

    assign w_in_flight = (r_state != ST_IDLE);
    assign w_overrun   = update_address & w_in_flight;
    assign w_b_bus_en  = data_out_en & data_prov_b_bus_en;

    // Address source select; accesses are always word aligned.
    always_comb begin
        w_addr_src = r_addr;
        case (address_reg_sel)
            2'b00:   w_addr_src = alu_bus;
            2'b01:   w_addr_src = pc_bus;
            2'b10:   w_addr_src = r_addr + 32'd4;
            default: w_addr_src = r_addr;
        endcase
        w_addr_nxt = {w_addr_src[31:2], 2'b00};
    end

    // FSM next-state and transaction strobes; an ack coinciding with the timeout limit wins.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (update_address) begin
                    w_accept    = 1'b1;
                    w_state_nxt = mem_write_en ? ST_WRITE : ST_READ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (mem_ack) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request side: address, write data and request qualifiers held until the transaction ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_addr      <= RESET_ADDR;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end else if (w_accept) begin
            r_addr      <= w_addr_nxt;
            r_mem_wdata <= write_data;
            r_mem_req   <= 1'b1;
            r_mem_we    <= mem_write_en;
        end else if (w_complete || w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    // Response side: read data capture, timed-out reads return a NOP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr       <= NOP_WORD;
            r_load_data   <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            if (w_complete && (r_state == ST_READ)) begin
                r_instr       <= mem_rdata;
                r_load_data   <= mem_rdata;
                r_instr_valid <= 1'b1;
            end else if (w_timeout && (r_state == ST_READ)) begin
                r_instr       <= NOP_WORD;
                r_instr_valid <= 1'b1;
            end
        end
    end

    // Sticky flag for requests dropped because a transaction was already in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (w_overrun) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef MEM_DATA_PROVIDER_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_timeout_err;

    assign w_timeout_hit = (r_wait_cnt == CNT_LAST);
    assign timeout_err   = r_timeout_err;

    // Wait counter: cleared when a transaction starts, counts cycles without ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_wait_cnt <= {CNT_W{1'b0}};
        end else if (w_in_flight && !mem_ack) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    assign instruction = r_instr;
    assign instr_valid = r_instr_valid;
    assign busy        = r_mem_req;
    assign overrun     = r_overrun;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_addr[ADDR_W-1:0];
    assign mem_wdata   = r_mem_wdata;
    assign b_bus       = w_b_bus_en ? r_load_data : 32'hzzzz_zzzz;

endmodule
